fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_queue.sv | 39 +++
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared processor constants and the fetch queue payload type.
package fetch_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned CNT_W       = 2;

    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Two-entry in-order queue of fetched {pc, instr} pairs between imem and decode.
module fetch_queue
    import fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t mem [QUEUE_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    // Pointers and occupancy; a flush wins over any same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, credit-based imem requests and redirect
// handling in front of a two-entry queue feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  inflight_pc_q;
    logic             inflight_q;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             pop;
    logic             push;
    logic [2:0]       pending;

    // Credit check counts the queue, the in-flight slot and this cycle's pop.
    always_comb begin
        id_valid  = !reset && (count != '0);
        id_pc     = reset ? '0 : head.pc;
        id_instr  = reset ? '0 : head.instr;
        pop       = id_valid && id_ready;
        pending   = 3'(count) + 3'(inflight_q) - 3'(pop);
        imem_req  = !reset && !redirect_valid && (pending < 3'd2);
        push      = inflight_q && !redirect_valid && !reset;
        imem_addr = pc_q;
        push_data = '{pc: inflight_pc_q, instr: imem_rdata};
    end

    // A redirect clears the in-flight slot so its response is never pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc & ~32'd3;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a queue-based behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: the decode-visible queue plus the next fetch address.
    ent_t        mq[$];
    logic [31:0] m_pc = RST_PC;
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;

    // Instruction memory: answers the previous cycle's request with addr>>2.
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_instr;

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit   e_req, e_valid;
        ent_t e;
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        imem_rdata     = mem_pending ? (mem_addr >> 2) : $urandom;
        #1;
        o_req = imem_req;   o_addr  = imem_addr;
        o_valid = id_valid; o_pc    = id_pc;    o_instr = id_instr;

        e_valid = !rst && (mq.size() != 0);
        e_req   = !rst && !rv && ((mq.size() + int'(m_infl) - int'(e_valid && rdy)) < 2);

        n_cmp++;
        if (o_req !== e_req) begin
            n_fail++; $display("FAIL imem_req: got %b want %b t=%0t", o_req, e_req, $time);
        end
        if (e_req) begin
            n_cmp++;
            if (o_addr !== m_pc) begin
                n_fail++; $display("FAIL imem_addr: got %h want %h t=%0t", o_addr, m_pc, $time);
            end
        end
        n_cmp++;
        if (o_valid !== e_valid) begin
            n_fail++; $display("FAIL id_valid: got %b want %b t=%0t", o_valid, e_valid, $time);
        end
        if (e_valid) begin
            n_cmp++;
            if (o_pc !== mq[0].pc || o_instr !== mq[0].instr) begin
                n_fail++;
                $display("FAIL id_head: got %h/%h want %h/%h t=%0t",
                         o_pc, o_instr, mq[0].pc, mq[0].instr, $time);
            end
        end
        if (rst) begin
            n_cmp++;
            if (o_pc !== 32'd0 || o_instr !== 32'd0) begin
                n_fail++; $display("FAIL reset_outputs: got %h/%h want 0/0", o_pc, o_instr);
            end
        end

        mem_pending = o_req;
        mem_addr    = o_addr;

        if (rst) begin
            mq.delete();
            m_pc   = RST_PC;
            m_infl = 1'b0;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_infl && !rv) begin
                e.pc = m_infl_pc; e.instr = imem_rdata;
                mq.push_back(e);
            end
            if (rv) begin
                mq.delete();
                m_pc   = rpc & ~32'd3;
                m_infl = 1'b0;
            end else begin
                m_infl = e_req;
                if (e_req) begin
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, '0, 1);
            n_cmp++;
            if (o_req !== 1'b0 || o_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_state: req=%b valid=%b want 0/0", o_req, o_valid);
            end
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 7; k++) begin
            step(0, 0, '0, 1);
            n_cmp++;
            if (o_req !== 1'b1 || o_addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL stream_addr: got %b/%h want 1/%h", o_req, o_addr, 32'(4 * k));
            end
            n_cmp++;
            if (k < 2) begin
                if (o_valid !== 1'b0) begin
                    n_fail++; $display("FAIL stream_latency: valid=%b want 0 at k=%0d", o_valid, k);
                end
            end else if (o_valid !== 1'b1 || o_pc !== 32'(4 * (k - 2)) || o_instr !== (o_pc >> 2)) begin
                n_fail++;
                $display("FAIL stream_pc: got %b/%h/%h want 1/%h", o_valid, o_pc, o_instr, 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h, hi;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0);
            if (i == 0) begin h = o_pc; hi = o_instr; end
            n_cmp++;
            if (o_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== h || o_instr !== hi) begin
                n_fail++;
                $display("FAIL stall_hold: req=%b valid=%b pc=%h instr=%h want 0/1/%h/%h",
                         o_req, o_valid, o_pc, o_instr, h, hi);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, '0, 1);
            n_cmp++;
            if (o_valid !== 1'b1 || o_pc !== h + 32'(4 * i)) begin
                n_fail++; $display("FAIL stall_drain: valid=%b pc=%h want 1/%h", o_valid, o_pc, h + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_full();
        int seen;
        step(0, 0, '0, 1);
        step(0, 1, 32'h0000_0103, 0);
        step(0, 0, '0, 1);
        n_cmp++;
        if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_next: valid=%b req=%b addr=%h want 0/1/00000100", o_valid, o_req, o_addr);
        end
        seen = -1;
        for (int i = 0; i < 6 && seen < 0; i++) begin
            step(0, 0, '0, 1);
            if (o_valid) seen = i;
        end
        n_cmp++;
        if (seen != 1 || o_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL redirect_first: idx=%0d pc=%h want 1/00000100", seen, o_pc);
        end
    endtask

    task automatic test_redirect_pop_resp();
        int seen;
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        step(0, 1, 32'h0000_2000, 1);
        n_cmp++;
        if (o_valid !== 1'b1) begin
            n_fail++; $display("FAIL redirect_pop: valid=%b want 1", o_valid);
        end
        seen = -1;
        for (int i = 0; i < 6 && seen < 0; i++) begin
            step(0, 0, '0, 1);
            if (o_valid) seen = i;
        end
        n_cmp++;
        if (seen < 0 || o_pc !== 32'h0000_2000) begin
            n_fail++; $display("FAIL redirect_target: idx=%0d pc=%h want 00002000", seen, o_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
        step(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 1);
            n_cmp++;
            if (o_req !== 1'b1 || o_addr !== exp_addr[i]) begin
                n_fail++; $display("FAIL wrap_addr: got %b/%h want 1/%h", o_req, o_addr, exp_addr[i]);
            end
        end
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        step(1, 0, '0, 1);
        step(0, 0, '0, 1);
        n_cmp++;
        if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== RST_PC) begin
            n_fail++; $display("FAIL mid_reset: valid=%b req=%b addr=%h want 0/1/%h", o_valid, o_req, o_addr, RST_PC);
        end
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        n_cmp++;
        if (o_valid !== 1'b1 || o_pc !== RST_PC) begin
            n_fail++; $display("FAIL mid_reset_first: valid=%b pc=%h want 1/%h", o_valid, o_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step(($urandom % 64) == 0, ($urandom % 12) == 0, $urandom, ($urandom % 4) != 0);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; imem_rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop_resp();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
